// File: rtl/silife_gen_ctrl.sv
// Wishbone-controlled generation sequencer for the silife Game-of-Life array.
// Optional done flag / irq logic is built only when SILIFE_GEN_CTRL_IRQ_EN is defined.
module silife_gen_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HEIGHT   = 8,
    parameter int unsigned DIV_BITS = 24,
    parameter int unsigned GEN_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        step,
    output logic        invert,
    output logic [15:0] scan_cycles,
    output logic        irq
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FREE    = 2'd1;
    localparam logic [1:0] ST_BOUNDED = 2'd2;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_DIV    = 8'h04;
    localparam logic [7:0] ADDR_GEN    = 8'h08;
    localparam logic [7:0] ADDR_RUN_N  = 8'h0C;
    localparam logic [7:0] ADDR_STATUS = 8'h10;
    localparam logic [7:0] ADDR_SCAN   = 8'h14;
    localparam logic [7:0] ADDR_ID     = 8'h18;

    localparam logic [15:0] SCAN_RST = 16'd3;

    logic [1:0]          state_q, state_d;
    logic                run_q, run_d;
    logic                invert_q, invert_d;
    logic [DIV_BITS-1:0] div_q, div_d;
    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [GEN_BITS-1:0] gen_q, gen_d;
    logic [GEN_BITS-1:0] remain_q, remain_d;
    logic [15:0]         scan_q, scan_d;
    logic                pend_q, pend_d;
    logic                step_q, step_d;
    logic                ack_q, ack_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                irq_q, irq_d;

    logic                done_c;
    logic                irq_en_c;

    logic                req_c, wr_c, rd_c;
    logic [7:0]          addr_c;
    logic                wr_ctrl_c, wr_div_c, wr_gen_c, wr_runn_c, wr_status_c, wr_scan_c;
    logic [GEN_BITS-1:0] runn_val_c;
    logic                runn_nz_c;
    logic                tick_c;
    logic                unused_c;

    // Bus decode: a request is only new while ack is low
    assign req_c       = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr_c        = req_c & i_wb_we;
    assign rd_c        = req_c & ~i_wb_we;
    assign addr_c      = i_wb_addr[7:0];
    assign wr_ctrl_c   = wr_c && (addr_c == ADDR_CTRL);
    assign wr_div_c    = wr_c && (addr_c == ADDR_DIV);
    assign wr_gen_c    = wr_c && (addr_c == ADDR_GEN);
    assign wr_runn_c   = wr_c && (addr_c == ADDR_RUN_N);
    assign wr_status_c = wr_c && (addr_c == ADDR_STATUS);
    assign wr_scan_c   = wr_c && (addr_c == ADDR_SCAN);
    assign runn_val_c  = i_wb_data[GEN_BITS-1:0];
    assign runn_nz_c   = |runn_val_c;
    assign tick_c      = (state_q != ST_IDLE) && (presc_q == '0);
    assign unused_c    = &{1'b0, i_wb_addr[31:8], i_wb_data};

`ifdef SILIFE_GEN_CTRL_IRQ_EN
    logic done_q, done_d;
    logic irq_en_q, irq_en_d;

    assign done_c   = done_q;
    assign irq_en_c = irq_en_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
        end
    end
`else
    assign done_c   = 1'b0;
    assign irq_en_c = 1'b0;
`endif

    // Next-state: registers, prescaler, step generation, FSM and read mux
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        invert_d = invert_q;
        div_d    = div_q;
        presc_d  = presc_q;
        gen_d    = gen_q;
        remain_d = remain_q;
        scan_d   = scan_q;
        pend_d   = 1'b0;
        step_d   = 1'b0;
        ack_d    = i_wb_cyc & i_wb_stb & ~ack_q;
        rdata_d  = 32'h0;
        irq_d    = done_c & irq_en_c;
`ifdef SILIFE_GEN_CTRL_IRQ_EN
        done_d   = done_q;
        irq_en_d = irq_en_q;
`endif

        if (state_q != ST_IDLE) begin
            presc_d = tick_c ? div_q : presc_q - DIV_BITS'(1);
        end

        // A pending step_req and a tick in the same cycle merge into one pulse
        step_d = tick_c | pend_q;
        if (step_d) begin
            gen_d = gen_q + GEN_BITS'(1);
        end

        if (wr_ctrl_c) begin
            run_d    = i_wb_data[0];
            invert_d = i_wb_data[1];
            pend_d   = i_wb_data[2];
`ifdef SILIFE_GEN_CTRL_IRQ_EN
            irq_en_d = i_wb_data[3];
`endif
        end
        if (wr_div_c) begin
            div_d = i_wb_data[DIV_BITS-1:0];
        end
        if (wr_gen_c) begin
            gen_d = '0;
        end
        if (wr_runn_c) begin
            remain_d = runn_val_c;
        end
        if (wr_scan_c) begin
            scan_d = i_wb_data[15:0];
        end
`ifdef SILIFE_GEN_CTRL_IRQ_EN
        if (wr_status_c && i_wb_data[1]) begin
            done_d = 1'b0;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (wr_runn_c && runn_nz_c) begin
                    state_d = ST_BOUNDED;
                    presc_d = div_q;
                end else if (run_d) begin
                    state_d = ST_FREE;
                    presc_d = div_q;
                end
            end
            ST_FREE: begin
                if (wr_runn_c && runn_nz_c) begin
                    state_d = ST_BOUNDED;
                    presc_d = div_q;
                end else if (!run_d) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BOUNDED: begin
                if (wr_runn_c) begin
                    if (runn_nz_c) begin
                        presc_d = div_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tick_c) begin
                    remain_d = remain_q - GEN_BITS'(1);
                    if (remain_q == GEN_BITS'(1)) begin
                        state_d = ST_IDLE;
                        run_d   = 1'b0;
`ifdef SILIFE_GEN_CTRL_IRQ_EN
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_c) begin
            case (addr_c)
                ADDR_CTRL:   rdata_d = {28'd0, irq_en_c, 1'b0, invert_q, run_q};
                ADDR_DIV:    rdata_d = 32'(div_q);
                ADDR_GEN:    rdata_d = 32'(gen_q);
                ADDR_RUN_N:  rdata_d = 32'(remain_q);
                ADDR_STATUS: rdata_d = {30'd0, done_c, (state_q != ST_IDLE)};
                ADDR_SCAN:   rdata_d = {16'd0, scan_q};
                ADDR_ID:     rdata_d = {8'h51, 8'h00, 8'(HEIGHT), 8'(WIDTH)};
                default:     rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            run_q    <= 1'b0;
            invert_q <= 1'b0;
            div_q    <= '0;
            presc_q  <= '0;
            gen_q    <= '0;
            remain_q <= '0;
            scan_q   <= SCAN_RST;
            pend_q   <= 1'b0;
            step_q   <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= 32'h0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            invert_q <= invert_d;
            div_q    <= div_d;
            presc_q  <= presc_d;
            gen_q    <= gen_d;
            remain_q <= remain_d;
            scan_q   <= scan_d;
            pend_q   <= pend_d;
            step_q   <= step_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign o_wb_ack    = ack_q;
    assign o_wb_data   = rdata_q;
    assign step        = step_q;
    assign invert      = invert_q;
    assign scan_cycles = scan_q;
    assign irq         = irq_q;

endmodule

// File: doc/silife_gen_ctrl.md
Name: silife_gen_ctrl

Overview:
- Wishbone-controlled generation sequencer for the silife Game-of-Life array.
- Replaces the fixed enable/pulse control with three stepping modes: free-run at a programmable rate, bounded run of N generations, and single step.
- Also provides a generation counter, scan configuration and a done interrupt.
- Sits between the Wishbone bus and the matrix/scan blocks; drives the matrix enable (`step`), scan `invert` and `scan_cycles`.

Parameters:
- WIDTH, 8, matrix column count (reported in ID register only)
- HEIGHT, 8, matrix row count (reported in ID register only)
- DIV_BITS, 24, width of rate prescaler reload (2..32)
- GEN_BITS, 32, width of generation counter and run-N counter (8..32)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_wb_cyc  in  1  Wishbone cycle
- i_wb_stb  in  1  Wishbone strobe (already qualified to this block's region by the top level)
- i_wb_we  in  1  write enable
- i_wb_addr  in  32  byte address; only [7:0] decoded
- i_wb_data  in  32  write data
- o_wb_ack  out  1  transfer acknowledge
- o_wb_data  out  32  read data
- step  out  1  one-cycle pulse; matrix computes one generation on this cycle
- invert  out  1  scan polarity
- scan_cycles  out  16  scan dwell per row
- irq  out  1  level interrupt, done & irq_en

Behaviour:
- Reset (async, all outputs): step=0, invert=0, scan_cycles=3, irq=0, o_wb_ack=0, o_wb_data=0. All registers zero except SCAN=3. FSM=IDLE.
- Bus protocol:
  - Ack is registered: `o_wb_ack <= cyc & stb & !o_wb_ack`. Ack is a one-cycle pulse, one clock after the strobe is seen.
  - Back-to-back strobes therefore ack every other cycle.
  - Read data is valid in the same cycle as ack.
  - Writes take effect on the ack cycle edge.
  - Undecoded offsets read 0; writes to them are ignored but still acked.
- Register map (byte offsets):
  - 0x00 CTRL rw: [0] run (free-run), [1] invert, [2] step_req (write-1 pulse, reads 0), [3] irq_en.
  - 0x04 DIV rw: prescaler reload, DIV_BITS wide, zero-extended on read.
  - 0x08 GEN r: generations since clear. Any write clears it to 0.
  - 0x0C RUN_N rw: writing N>0 starts a bounded run. Writing 0 aborts a bounded run. Read returns remaining count.
  - 0x10 STATUS: [0] busy (ro), [1] done (sticky; write 1 clears).
  - 0x14 SCAN rw: [15:0] scan_cycles.
  - 0x18 ID ro: {8'h51, 8'h00, HEIGHT[7:0], WIDTH[7:0]}.
- Prescaler:
  - Counter loads DIV on FSM entry to FREE or BOUNDED, and after every tick.
  - Decrements each clock; a tick occurs when the counter is 0. The period is therefore DIV+1 clocks.
  - DIV=0 gives a tick every clock.
- FSM:
  - IDLE: no ticks. Enter FREE when run=1. Enter BOUNDED on a RUN_N write with N>0; this has priority over run.
  - FREE: step on each tick. Return to IDLE when run is cleared.
  - BOUNDED: step on each tick and decrement remaining.
    - When remaining goes 1→0: set done, clear run, go to IDLE.
    - A RUN_N write of 0 goes to IDLE without setting done.
    - A RUN_N write of N>0 while in BOUNDED reloads remaining and restarts the prescaler.
  - busy = (FSM != IDLE).
- step_req:
  - Produces a step pulse in the cycle after the write ack, in any state.
  - If it coincides with a tick, only one step pulse is issued; GEN increments by 1 and remaining decrements by 1.
- GEN:
  - Increments on every step pulse and wraps modulo 2^GEN_BITS.
  - A GEN write coinciding with a step leaves GEN=0 (the clear wins).
- done:
  - If a done set coincides with a W1C clear, done stays set.
- irq = done & irq_en, registered.

Optional Feature:
- Macro: SILIFE_GEN_CTRL_IRQ_EN.
- Defined: done flag, irq_en bit and irq output operate as described above.
- Undefined:
  - irq is tied 0.
  - STATUS[1] and CTRL[3] read 0 and writes to them are ignored.
  - No done logic is synthesised.

Test Plan:
- Reset mid-run → all outputs and registers return to reset values asynchronously:
  - Setup: DIV=3, CTRL=1. Assert reset after 5 steps.
  - Expect: step=0, GEN=0, SCAN=3 while reset is high; no step for 20 clocks after release.
- Free-run rate:
  - Stimulus: DIV=3, CTRL=0x1, run 40 clocks, then CTRL=0.
  - Expect: step pulses exactly 4 clocks apart, GEN=10±1; no further steps after the CTRL=0 ack.
- Bounded run:
  - Stimulus: DIV=0, RUN_N=5.
  - Expect: exactly 5 consecutive step pulses, then busy=0, done=1, RUN_N=0, GEN=5.
  - With irq_en=1: irq=1 until STATUS is written with 0x2.
- Single step and coincidence:
  - Stimulus: in IDLE, write CTRL=0x4.
  - Expect: one step pulse, GEN=1.
  - Stimulus: during FREE with DIV=0, write step_req.
  - Expect: still one pulse per cycle; GEN increments by exactly 1 per cycle.
- Abort and reload:
  - Stimulus: RUN_N=100 with DIV=1; after 10 steps write RUN_N=3.
  - Expect: exactly 3 more steps (GEN=13), then done=1.
  - Stimulus: separate run of RUN_N=100; after 10 steps write RUN_N=0.
  - Expect: busy=0, done=0.
- Bus/register checks:
  - Read ID with WIDTH=16, HEIGHT=8 → 0x51000810.
  - Write SCAN=0x1234 → scan_cycles=0x1234.
  - Read 0x1C → 0.
  - Hold stb high for 6 cycles → exactly 3 ack pulses.
